alu_unit: RTL and testbench

ALU_UNIT -- requirements
Module: alu_unit

---
 rtl/alu_unit.sv | 65 ++++++
 tb/tb_alu_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_unit.sv
// Registered ALU: AND/OR/ADD/SUB/XOR/NOR/SLTU/SLT over WIDTH-bit operands.
// Latency 1 cycle, one operation per cycle; no handshake, so no backpressure.
module alu_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUOperation,
  output logic [WIDTH-1:0] res,
  output logic             zero
);

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_XOR  = 3'b100,
    OP_NOR  = 3'b101,
    OP_SLTU = 3'b110,
    OP_SLT  = 3'b111
  } alu_op_t;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             lt_signed;
  logic             lt_unsigned;
  logic [WIDTH-1:0] nxt_res;

  assign sum  = A + B;
  assign diff = A - B;

  // Direct comparisons rather than the sign of diff, so SLT stays correct on overflow.
  assign lt_unsigned = (A < B);
  assign lt_signed   = ($signed(A) < $signed(B));

  always_comb begin
    nxt_res = '0;
    case (ALUOperation)
      OP_AND:  nxt_res = A & B;
      OP_OR:   nxt_res = A | B;
      OP_ADD:  nxt_res = sum;
      OP_SUB:  nxt_res = diff;
      OP_XOR:  nxt_res = A ^ B;
      OP_NOR:  nxt_res = ~(A | B);
      OP_SLTU: nxt_res = {{(WIDTH-1){1'b0}}, lt_unsigned};
      OP_SLT:  nxt_res = {{(WIDTH-1){1'b0}}, lt_signed};
      // Unknown select bits fall here and load a zero result.
      default: nxt_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res  <= '0;
      zero <= 1'b1;
    end else begin
      res  <= nxt_res;
      zero <= (nxt_res == '0);
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// Directed-vector bench for alu_unit with hand-computed expectations.
module tb_alu_unit;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   op;
  logic [W-1:0] res;
  logic         zero;

  int checks;
  int errors;

  alu_unit #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .A            (a),
    .B            (b),
    .ALUOperation (op),
    .res          (res),
    .zero         (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive on the falling edge, then observe just after the next rising edge.
  task automatic apply(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [2:0] ov);
    @(negedge clk);
    a  = av;
    b  = bv;
    op = ov;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    a = 32'h1234_5678; b = 32'h1; op = 3'b010;
    #3;
    checks++;
    if (res !== 32'h0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL reset_async res=%h zero=%b want res=0 zero=1", res, zero);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (res !== 32'h0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL reset_hold res=%h zero=%b want res=0 zero=1", res, zero);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add;
    apply(32'd5, 32'd2, 3'b010);
    checks++;
    if (res !== 32'd7 || zero !== 1'b0) begin
      errors++;
      $display("FAIL add_5_2 res=%h zero=%b want res=7 zero=0", res, zero);
    end
  endtask

  task automatic test_sub;
    apply(32'd7, 32'hFFFF_FFFD, 3'b011);
    checks++;
    if (res !== 32'd10 || zero !== 1'b0) begin
      errors++;
      $display("FAIL sub_7_m3 res=%h zero=%b want res=a zero=0", res, zero);
    end
    apply(32'd9, 32'd9, 3'b011);
    checks++;
    if (res !== 32'd0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL sub_9_9 res=%h zero=%b want res=0 zero=1", res, zero);
    end
  endtask

  task automatic test_logic;
    apply(32'h007F_FFFF, 32'h8780_7C1C, 3'b000);
    checks++;
    if (res !== 32'h0000_7C1C || zero !== 1'b0) begin
      errors++;
      $display("FAIL and res=%h zero=%b want res=00007c1c zero=0", res, zero);
    end
    apply(32'hF0F0_0000, 32'h0000_0F0F, 3'b001);
    checks++;
    if (res !== 32'hF0F0_0F0F) begin
      errors++;
      $display("FAIL or res=%h want f0f00f0f", res);
    end
    apply(32'hFFFF_0000, 32'h0FF0_0FF0, 3'b100);
    checks++;
    if (res !== 32'hF00F_0FF0) begin
      errors++;
      $display("FAIL xor res=%h want f00f0ff0", res);
    end
    apply(32'h0, 32'h0, 3'b101);
    checks++;
    if (res !== 32'hFFFF_FFFF || zero !== 1'b0) begin
      errors++;
      $display("FAIL nor_0_0 res=%h zero=%b want res=ffffffff zero=0", res, zero);
    end
    apply(32'hFFFF_0000, 32'h0000_FFFF, 3'b101);
    checks++;
    if (res !== 32'h0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL nor_full res=%h zero=%b want res=0 zero=1", res, zero);
    end
  endtask

  task automatic test_slt;
    logic [W-1:0] va [5];
    logic [W-1:0] vb [5];
    logic [W-1:0] ve [5];
    va = '{32'd2, 32'hFFFF_FFFA, 32'd14, 32'h7FFF_FFFF, 32'h8000_0000};
    vb = '{32'd4, 32'd2,         32'd2,  32'h8000_0000, 32'h7FFF_FFFF};
    ve = '{32'd1, 32'd1,         32'd0,  32'd0,         32'd1};
    for (int i = 0; i < 5; i++) begin
      apply(va[i], vb[i], 3'b111);
      checks++;
      if (res !== ve[i] || zero !== (ve[i] == 32'd0)) begin
        errors++;
        $display("FAIL slt_%0d res=%h zero=%b want res=%h", i, res, zero, ve[i]);
      end
    end
  endtask

  task automatic test_sltu;
    apply(32'hFFFF_FFFA, 32'd2, 3'b110);
    checks++;
    if (res !== 32'd0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL sltu_big_small res=%h zero=%b want res=0 zero=1", res, zero);
    end
    apply(32'd2, 32'hFFFF_FFFA, 3'b110);
    checks++;
    if (res !== 32'd1 || zero !== 1'b0) begin
      errors++;
      $display("FAIL sltu_small_big res=%h zero=%b want res=1 zero=0", res, zero);
    end
    apply(32'd5, 32'd5, 3'b110);
    checks++;
    if (res !== 32'd0) begin
      errors++;
      $display("FAIL sltu_equal res=%h want 0", res);
    end
  endtask

  task automatic test_wrap;
    apply(32'h7FFF_FFFF, 32'd1, 3'b010);
    checks++;
    if (res !== 32'h8000_0000) begin
      errors++;
      $display("FAIL add_wrap_pos res=%h want 80000000", res);
    end
    apply(32'hFFFF_FFFF, 32'd1, 3'b010);
    checks++;
    if (res !== 32'h0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL add_wrap_full res=%h zero=%b want res=0 zero=1", res, zero);
    end
    apply(32'h0, 32'd1, 3'b011);
    checks++;
    if (res !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL sub_wrap res=%h want ffffffff", res);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] va [4];
    logic [W-1:0] vb [4];
    logic [2:0]   vo [4];
    logic [W-1:0] ve [4];
    va = '{32'd100, 32'd100, 32'h0000_00FF, 32'd3};
    vb = '{32'd23,  32'd23,  32'h0000_0F0F, 32'd3};
    vo = '{3'b010,  3'b011,  3'b000,        3'b100};
    ve = '{32'd123, 32'd77,  32'h0000_000F, 32'd0};
    for (int i = 0; i < 4; i++) begin
      apply(va[i], vb[i], vo[i]);
      checks++;
      if (res !== ve[i] || zero !== (ve[i] == 32'd0)) begin
        errors++;
        $display("FAIL b2b_%0d res=%h zero=%b want res=%h", i, res, zero, ve[i]);
      end
    end
  endtask

  task automatic test_hold;
    apply(32'd40, 32'd2, 3'b010);
    a = 32'd0; b = 32'd0; op = 3'b000;
    #3;
    checks++;
    if (res !== 32'd42 || zero !== 1'b0) begin
      errors++;
      $display("FAIL hold_between_edges res=%h zero=%b want res=2a zero=0", res, zero);
    end
  endtask

  task automatic test_reset_mid;
    apply(32'd5, 32'd2, 3'b010);
    // Set up a pending op, then reset before the edge that would load it.
    a = 32'd1; b = 32'd1; op = 3'b010;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (res !== 32'h0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_immediate res=%h zero=%b want res=0 zero=1", res, zero);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (res !== 32'h0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_hold res=%h zero=%b want res=0 zero=1", res, zero);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (res !== 32'd2 || zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_resume res=%h zero=%b want res=2 zero=0", res, zero);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    a = '0; b = '0; op = '0;
    test_reset;
    test_add;
    test_sub;
    test_logic;
    test_slt;
    test_sltu;
    test_wrap;
    test_back_to_back;
    test_hold;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
